// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between the echo path and the result encoder.
// Each source has its own byte FIFO. Once a result message has started, it keeps the transmitter until that message is drained.
module uart_tx_sched_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              push,
   input  logic              pop,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              empty,
   output logic              drop,
   output logic [ADDR_W:0]   count_nxt
);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              do_push;
   logic              do_pop;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
   always_comb begin
      full      = (count == FULL_CNT);
      empty     = (count == '0);
      do_pop    = pop && !empty;
      do_push   = push && (!full || do_pop);
      drop      = push && full && !do_pop;
      rdata     = mem[rd_ptr];
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (!do_push && do_pop)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (do_push)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
   end
endmodule

module uart_tx_sched #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int BUSY_TO = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       echo_valid,
   input  logic [7:0] echo_data,
   input  logic       uout_valid,
   input  logic [7:0] tx_data,
   input  logic       uart_busy,
   output logic       uart_start,
   output logic [7:0] uart_data,
   output logic       echo_ovf,
   output logic       res_ovf,
   input  logic       clr_ovf,
   output logic       sched_idle
);
   localparam int TO_W = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state;
   logic              lock;
   logic [TO_W-1:0]   to_cnt;
   logic              sel_echo;
   logic              sel_res;
   logic              going_idle;
   logic [7:0]        echo_rdata;
   logic [7:0]        res_rdata;
   logic              echo_empty;
   logic              res_empty;
   logic              echo_drop;
   logic              res_drop;
   logic [ADDR_W:0]   echo_cnt_nxt;
   logic [ADDR_W:0]   res_cnt_nxt;

   uart_tx_sched_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_echo_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (echo_valid),
      .pop       (sel_echo),
      .wdata     (echo_data),
      .rdata     (echo_rdata),
      .empty     (echo_empty),
      .drop      (echo_drop),
      .count_nxt (echo_cnt_nxt)
   );

   uart_tx_sched_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_res_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (uout_valid),
      .pop       (sel_res),
      .wdata     (tx_data),
      .rdata     (res_rdata),
      .empty     (res_empty),
      .drop      (res_drop),
      .count_nxt (res_cnt_nxt)
   );

   // A result message in flight takes precedence. Otherwise echo bytes go before a new message.
   always_comb begin
      sel_echo = 1'b0;
      sel_res  = 1'b0;
      if (state == IDLE && !uart_busy) begin
         if (lock && !res_empty)
            sel_res = 1'b1;
         else if (!echo_empty)
            sel_echo = 1'b1;
         else if (!res_empty)
            sel_res = 1'b1;
      end
      going_idle = 1'b0;
      case (state)
         IDLE:      going_idle = !(sel_echo || sel_res);
         WAIT_BUSY: going_idle = !uart_busy && (to_cnt == TO_LAST);
         WAIT_DONE: going_idle = !uart_busy;
         default:   going_idle = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         lock       <= 1'b0;
         to_cnt     <= '0;
         uart_start <= 1'b0;
         uart_data  <= '0;
         sched_idle <= 1'b1;
      end else begin
         uart_start <= 1'b0;
         sched_idle <= going_idle && (echo_cnt_nxt == '0) && (res_cnt_nxt == '0);
         case (state)
            IDLE: begin
               if (sel_res)
                  lock <= 1'b1;
               else if (res_empty)
                  lock <= 1'b0;
               if (sel_res) begin
                  uart_data  <= res_rdata;
                  uart_start <= 1'b1;
                  state      <= START;
               end else if (sel_echo) begin
                  uart_data  <= echo_rdata;
                  uart_start <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               to_cnt <= '0;
               state  <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (uart_busy)
                  state <= WAIT_DONE;
               else if (to_cnt == TO_LAST)
                  state <= IDLE;
               else
                  to_cnt <= to_cnt + 1'b1;
            end
            WAIT_DONE: begin
               if (!uart_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         echo_ovf <= 1'b0;
         res_ovf  <= 1'b0;
      end else begin
         echo_ovf <= echo_drop || (echo_ovf && !clr_ovf);
         res_ovf  <= res_drop  || (res_ovf  && !clr_ovf);
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a behavioural UART busy model.
// Expected bytes are queued in transmit order as stimulus is driven, and are checked on each uart_start.
module tb_uart_tx_sched;
   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int BUSY_TO  = 4;
   localparam int BUSY_LEN = 10;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       echo_valid = 1'b0;
   logic [7:0] echo_data = '0;
   logic       uout_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       uart_busy = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       uart_start;
   logic [7:0] uart_data;
   logic       echo_ovf;
   logic       res_ovf;
   logic       sched_idle;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         start_cnt = 0;
   int         strobe_cyc = 0;
   int         base = 0;
   int         first_strobe = 0;
   int         mdl_left = 0;
   bit         mdl_pend = 1'b0;
   bit         hold_busy = 1'b0;
   bit         no_busy = 1'b0;
   logic [7:0] exp_q[$];
   int         start_cyc[$];
   logic [7:0] msg [6] = '{8'h20, 8'h49, 8'h3D, 8'h31, 8'h32, 8'h33};

   uart_tx_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TO(BUSY_TO)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .echo_valid (echo_valid),
      .echo_data  (echo_data),
      .uout_valid (uout_valid),
      .tx_data    (tx_data),
      .uart_busy  (uart_busy),
      .uart_start (uart_start),
      .uart_data  (uart_data),
      .echo_ovf   (echo_ovf),
      .res_ovf    (res_ovf),
      .clr_ovf    (clr_ovf),
      .sched_idle (sched_idle)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // UART model: busy rises one cycle after the start pulse and stays high for BUSY_LEN cycles.
   initial forever begin
      @(negedge clk);
      if (!n_rst) begin
         mdl_left  = 0;
         mdl_pend  = 1'b0;
         uart_busy = 1'b0;
      end else if (hold_busy) begin
         uart_busy = 1'b1;
      end else begin
         if (mdl_pend) begin
            mdl_pend = 1'b0;
            mdl_left = BUSY_LEN;
         end
         if (mdl_left > 0) begin
            uart_busy = 1'b1;
            mdl_left--;
         end else begin
            uart_busy = 1'b0;
         end
         if (uart_start && !no_busy)
            mdl_pend = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (n_rst && uart_start) begin
         start_cnt++;
         start_cyc.push_back(cyc);
         chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            chk("uart_data", 32'(uart_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic drive(input bit res, input logic [7:0] d, input bit expect_tx);
      @(negedge clk);
      echo_valid = !res;
      uout_valid = res;
      echo_data  = d;
      tx_data    = d;
      if (expect_tx)
         exp_q.push_back(d);
      strobe_cyc = cyc;
   endtask

   task automatic quiet();
      @(negedge clk);
      echo_valid = 1'b0;
      uout_valid = 1'b0;
      clr_ovf    = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int from, input int budget);
      int k = 0;
      while (start_cnt <= from && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_start_seen"}, 32'(start_cnt > from), 32'd1);
   endtask

   task automatic wait_drain(input string tag, input int from, input int n, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || !sched_idle || uart_busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_starts"}, 32'(start_cnt - from), 32'(n));
      chk({tag, "_idle"}, 32'(sched_idle), 32'd1);
   endtask

   task automatic ovf_test(input bit res, input string pfx);
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      base = start_cnt;
      for (int i = 0; i < DEPTH; i++)
         drive(res, 8'(8'h40 + i), 1'b1);
      quiet();
      chk({pfx, "_ovf_at_full"}, 32'(res ? res_ovf : echo_ovf), 32'd0);
      drive(res, 8'hEE, 1'b0);
      quiet();
      chk({pfx, "_ovf_set"}, 32'(res ? res_ovf : echo_ovf), 32'd1);
      drive(res, 8'hEF, 1'b0);
      clr_ovf = 1'b1;
      quiet();
      chk({pfx, "_ovf_set_wins"}, 32'(res ? res_ovf : echo_ovf), 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk({pfx, "_ovf_cleared"}, 32'(res ? res_ovf : echo_ovf), 32'd0);
      chk({pfx, "_other_ovf"}, 32'(res ? echo_ovf : res_ovf), 32'd0);
      hold_busy = 1'b0;
      wait_drain({pfx, "_ovf"}, base, DEPTH, 800);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_start", 32'(uart_start), 32'd0);
      chk("rst_data", 32'(uart_data), 32'h00);
      chk("rst_echo_ovf", 32'(echo_ovf), 32'd0);
      chk("rst_res_ovf", 32'(res_ovf), 32'd0);
      chk("rst_idle", 32'(sched_idle), 32'd1);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      base = start_cnt;
      drive(1'b0, 8'h31, 1'b1);
      quiet();
      wait_drain("echo1", base, 1, 100);

      base = start_cnt;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, msg[i], 1'b1);
         if (i == 0)
            first_strobe = strobe_cyc;
      end
      quiet();
      wait_drain("msg", base, 6, 300);
      chk("msg_latency", 32'(start_cyc[base] - first_strobe), 32'd2);

      base = start_cnt;
      for (int i = 0; i < 4; i++)
         drive(1'b1, 8'(8'h31 + i), 1'b1);
      quiet();
      wait_start("lock", base, 50);
      drive(1'b0, 8'h2B, 1'b1);
      quiet();
      wait_drain("lock", base, 5, 300);

      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      base = start_cnt;
      drive(1'b1, 8'hA1, 1'b0);
      drive(1'b0, 8'hE1, 1'b1);
      quiet();
      exp_q.push_back(8'hA1);
      hold_busy = 1'b0;
      wait_drain("prio", base, 2, 100);

      ovf_test(1'b1, "res");
      ovf_test(1'b0, "echo");

      no_busy = 1'b1;
      base = start_cnt;
      drive(1'b0, 8'h55, 1'b1);
      drive(1'b0, 8'h56, 1'b1);
      quiet();
      wait_drain("tmo", base, 2, 100);
      if (start_cyc.size() >= base + 2)
         chk("tmo_gap", 32'(start_cyc[base+1] - start_cyc[base]), 32'(BUSY_TO + 2));
      else
         chk("tmo_gap_starts", 32'(start_cyc.size()), 32'(base + 2));
      no_busy = 1'b0;

      base = start_cnt;
      drive(1'b0, 8'hA0, 1'b1);
      for (int i = 1; i < 4; i++)
         drive(1'b0, 8'(8'hA0 + i), 1'b0);
      quiet();
      wait_start("rst_mid", base, 50);
      repeat (4) @(negedge clk);
      chk("rst_mid_busy", 32'(uart_busy), 32'd1);
      chk("rst_mid_not_idle", 32'(sched_idle), 32'd0);
      n_rst = 1'b0;
      #1;
      chk("rst_mid_start", 32'(uart_start), 32'd0);
      chk("rst_mid_data", 32'(uart_data), 32'h00);
      chk("rst_mid_idle", 32'(sched_idle), 32'd1);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_mid_no_start", 32'(start_cnt - base), 32'd1);
      chk("rst_mid_sb", 32'(exp_q.size()), 32'd0);
      chk("rst_mid_idle_after", 32'(sched_idle), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
